// File: rtl/fwspi_xip_pkg.sv
// fwspi_xip_pkg: shared states, command and bit-count constants for the SPI XIP target
package fwspi_xip_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, GAP} state_t;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int CMD_BITS = 8;
  localparam int ADR_BITS = 24;
  localparam int DAT_BITS = 32;
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/fwspi_xip_shifter.sv
// fwspi_xip_shifter: mode-0 SPI bit engine with SCK divider, MSB-first TX and RX shift registers
module fwspi_xip_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  len,
  input  logic [31:0] tx_word,
  output logic        done,
  output logic [31:0] rx_word,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic [5:0] bit_cnt;
  logic [31:0] tx_sr;
  logic busy;
  logic tick;
  assign tick = busy && div_cnt == DW'(CLK_DIV - 1);
  // done lands on the last cycle of the final bit so a follow-on start loses no clocks
  assign done = tick && spi_sck && bit_cnt == 6'd1;
  assign spi_mosi = busy && tx_sr[31];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      spi_sck <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr <= '0;
      rx_word <= '0;
    end else if (start) begin
      busy <= 1'b1;
      spi_sck <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= len;
      tx_sr <= tx_word;
    end else if (busy) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        spi_sck <= !spi_sck;
        if (!spi_sck) rx_word <= {rx_word[30:0], spi_miso};
        else begin
          tx_sr <= tx_sr << 1;
          bit_cnt <= bit_cnt - 1'b1;
          busy <= bit_cnt != 6'd1;
        end
      end
    end
endmodule

// File: rtl/fwspi_xip_wb.sv
// fwspi_xip_wb: Wishbone execute-in-place read port for SPI NOR flash with a one-word read buffer
module fwspi_xip_wb
  import fwspi_xip_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rt_adr,
  input  logic [31:0] rt_dat_w,
  output logic [31:0] rt_dat_r,
  input  logic        rt_cyc,
  input  logic        rt_stb,
  input  logic        rt_we,
  input  logic [3:0]  rt_sel,
  output logic        rt_ack,
  output logic        rt_err,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  state_t state, state_nxt;
  logic [21:0] buf_adr, req_adr;
  logic [31:0] buf_dat, tx_word, rx_word;
  logic [8:0] gap_cnt;
  logic [5:0] len;
  logic buf_vld, live, start, done, req, hit, miss_go;
  logic unused_ok;
  assign unused_ok = ^{rt_dat_w, rt_sel, rt_adr[31:24], rt_adr[1:0]};
  assign rt_err = 1'b0;
  assign req = rt_cyc && rt_stb && state == IDLE && !rt_ack;
  assign hit = buf_vld && buf_adr == rt_adr[23:2];
  assign miss_go = req && !rt_we && !hit;
  assign spi_cs_n = !(state inside {CMD, ADDR, DATA});
  fwspi_xip_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clock(clock),
    .reset(reset),
    .start(start),
    .len(len),
    .tx_word(tx_word),
    .done(done),
    .rx_word(rx_word),
    .spi_sck(spi_sck),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    start = 1'b0;
    len = 6'(CMD_BITS);
    tx_word = {CMD_READ, 24'h0};
    case (state)
      IDLE: if (miss_go) begin
        state_nxt = CMD;
        start = 1'b1;
      end
      CMD: if (done) begin
        state_nxt = ADDR;
        start = 1'b1;
        len = 6'(ADR_BITS);
        tx_word = {req_adr, 2'b00, 8'h00};
      end
      ADDR: if (done) begin
        state_nxt = DATA;
        start = 1'b1;
        len = 6'(DAT_BITS);
        tx_word = '0;
      end
      DATA: if (done) state_nxt = DONE;
      DONE: state_nxt = GAP;
      GAP: if (gap_cnt == 9'(2 * CLK_DIV - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // live tracks whether the master still owns the cycle that started the miss
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rt_ack <= 1'b0;
      rt_dat_r <= '0;
      buf_vld <= 1'b0;
      buf_adr <= '0;
      buf_dat <= '0;
      req_adr <= '0;
      live <= 1'b0;
      gap_cnt <= '0;
    end else begin
      rt_ack <= (req && (rt_we || hit)) || (state == DONE && live && rt_cyc);
      live <= state == IDLE ? miss_go : live && rt_cyc;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (req && !rt_we && hit) rt_dat_r <= buf_dat;
      if (miss_go) req_adr <= rt_adr[23:2];
      if (state == DONE) begin
        buf_vld <= 1'b1;
        buf_adr <= req_adr;
        buf_dat <= bswap(rx_word);
        rt_dat_r <= bswap(rx_word);
      end
    end
endmodule
